// File: rtl/demux_pkg.sv
// Shared sizing and FSM state type for the serial demux select scheduler.
package demux_pkg;

  localparam int N_CH    = 8;
  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/next_chan_find.sv
// Combinational search for the next enabled channel above cur, wrapping to the
// lowest enabled channel when none is higher.
module next_chan_find #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic [SEL_W-1:0] lowest
);

  logic [SEL_W-1:0] higher;
  logic             found;

  // Descending scan: the last hit written is the smallest qualifying index.
  always_comb begin
    lowest = '0;
    higher = '0;
    found  = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = SEL_W'(i);
      end
      if (mask[i] && (SEL_W'(i) > cur)) begin
        higher = SEL_W'(i);
        found  = 1'b1;
      end
    end
    wrap = ~found;
    nxt  = found ? higher : lowest;
  end

endmodule

// File: rtl/demux_sel_sched.sv
// Schedules a serial beat stream across the enabled outputs of a 1:N demux,
// visiting each enabled channel for a fixed number of accepted beats per frame.
module demux_sel_sched
  import demux_pkg::*;
#(
  parameter int N_CH    = demux_pkg::N_CH,
  parameter int SEL_W   = demux_pkg::SEL_W,
  parameter int DWELL_W = demux_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [N_CH-1:0]    chan_en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic               dout,
  output logic [SEL_W-1:0]   sel,
  output logic               dout_valid,
  output logic               busy,
  output logic               frame_done,
  output logic               cfg_err
);

  state_t             state_q, state_d;
  logic [N_CH-1:0]    en_q, en_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   cur_ch_q, cur_ch_d;
  logic               stop_pend_q, stop_pend_d;
  logic               dout_q, dout_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               dout_valid_q, dout_valid_d;
  logic               frame_done_q, frame_done_d;
  logic               cfg_err_q, cfg_err_d;

  logic [N_CH-1:0]    search_mask;
  logic [SEL_W-1:0]   nxt_ch;
  logic [SEL_W-1:0]   low_ch;
  logic               nxt_wrap;
  logic [DWELL_W-1:0] dwell_eff;

  // In IDLE the finder looks at the incoming mask to pick the first channel;
  // in RUN it walks the latched mask.
  assign search_mask = (state_q == IDLE) ? chan_en : en_q;
  assign dwell_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;

  next_chan_find #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_next_chan_find (
    .mask   (search_mask),
    .cur    (cur_ch_q),
    .nxt    (nxt_ch),
    .wrap   (nxt_wrap),
    .lowest (low_ch)
  );

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    dwell_d      = dwell_q;
    cnt_d        = cnt_q;
    cur_ch_d     = cur_ch_q;
    stop_pend_d  = stop_pend_q;
    dout_d       = dout_q;
    sel_d        = sel_q;
    dout_valid_d = 1'b0;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          if (chan_en != '0) begin
            en_d     = chan_en;
            dwell_d  = dwell_eff;
            cnt_d    = dwell_eff;
            cur_ch_d = low_ch;
            state_d  = RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          stop_pend_d = 1'b1;
        end
        if (din_valid) begin
          dout_d       = din;
          sel_d        = cur_ch_q;
          dout_valid_d = 1'b1;
          if (cnt_q <= DWELL_W'(1)) begin
            cnt_d    = dwell_q;
            cur_ch_d = nxt_ch;
            if (nxt_wrap) begin
              frame_done_d = 1'b1;
              // A stop arriving with the frame-ending beat still ends here.
              if (stop_pend_q || stop) begin
                state_d     = IDLE;
                stop_pend_d = 1'b0;
              end
            end
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      en_q         <= '0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      cur_ch_q     <= '0;
      stop_pend_q  <= 1'b0;
      dout_q       <= 1'b0;
      sel_q        <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      cur_ch_q     <= cur_ch_d;
      stop_pend_q  <= stop_pend_d;
      dout_q       <= dout_d;
      sel_q        <= sel_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign din_ready  = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign dout       = dout_q;
  assign sel        = sel_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule
